// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the unified-memory port arbiter.
// Starve-counter constants exist only when MEM_ARB_FAIRNESS_EN is defined.
package mem_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 16;
  localparam int unsigned DATA_W_DEF = 16;

`ifdef MEM_ARB_FAIRNESS_EN
  localparam int unsigned STARVE_W       = 4;
  localparam int unsigned STARVE_MAX_DEF = 4;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_e;

  typedef enum logic {
    FETCH = 1'b0,
    DATA  = 1'b1
  } arb_owner_e;

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported unified memory between instruction fetch and the MEM stage.
// Define MEM_ARB_FAIRNESS_EN to let a starved fetch win after STARVE_MAX data grants.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
`ifdef MEM_ARB_FAIRNESS_EN
  , parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_stall,
  input  logic              d_re,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_e        r_state;
  arb_owner_e        r_owner;
  logic              r_flushed;
  logic              r_mem_req;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_if_ack;
  logic              r_d_ack;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_d_rdata;

  logic w_d_pend;
  logic w_f_pend;
  logic w_grant;
  logic w_pick_data;
  logic w_fetch_live;

  // A flushed fetch is not eligible for a grant in the same cycle.
  assign w_d_pend     = d_re | d_we;
  assign w_f_pend     = if_req & ~if_flush;
  assign w_grant      = w_d_pend | w_f_pend;
  assign w_fetch_live = ~r_flushed & ~if_flush;

`ifdef MEM_ARB_FAIRNESS_EN
  logic [STARVE_W-1:0] r_starve;
  logic                w_fetch_turn;

  assign w_fetch_turn = w_f_pend & (r_starve >= STARVE_W'(STARVE_MAX));
  assign w_pick_data  = w_d_pend & ~w_fetch_turn;

  // Counts data grants that overtook a waiting fetch; saturates rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_starve <= '0;
    end else if (r_state == IDLE && w_grant) begin
      if (!w_pick_data) begin
        r_starve <= '0;
      end else if (if_req && r_starve != {STARVE_W{1'b1}}) begin
        r_starve <= r_starve + STARVE_W'(1);
      end
    end
  end
`else
  assign w_pick_data = w_d_pend;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_owner     <= FETCH;
      r_flushed   <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_if_ack    <= 1'b0;
      r_d_ack     <= 1'b0;
      r_if_rdata  <= '0;
      r_d_rdata   <= '0;
    end else begin
      r_if_ack <= 1'b0;
      r_d_ack  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_state   <= BUSY;
            r_mem_req <= 1'b1;
            r_flushed <= 1'b0;
            if (w_pick_data) begin
              r_owner     <= DATA;
              r_mem_we    <= d_we;
              r_mem_addr  <= d_addr;
              r_mem_wdata <= d_wdata;
            end else begin
              r_owner     <= FETCH;
              r_mem_we    <= 1'b0;
              r_mem_addr  <= if_addr;
              r_mem_wdata <= '0;
            end
          end
        end
        BUSY: begin
          if (r_owner == FETCH && if_flush) begin
            r_flushed <= 1'b1;
          end
          // Memory side always completes; only the fetch response is dropped on flush.
          if (mem_ack) begin
            r_mem_req <= 1'b0;
            r_state   <= RESP;
            if (r_owner == DATA) begin
              r_d_ack <= 1'b1;
              if (!r_mem_we) begin
                r_d_rdata <= mem_rdata;
              end
            end else if (w_fetch_live) begin
              r_if_ack   <= 1'b1;
              r_if_rdata <= mem_rdata;
            end
          end
        end
        RESP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // A flush arriving in the response cycle still cancels the fetch acknowledge.
  assign if_ack    = r_if_ack & ~if_flush;
  assign if_rdata  = r_if_rdata;
  assign if_stall  = if_req & ~if_ack;
  assign d_ack     = r_d_ack;
  assign d_rdata   = r_d_rdata;
  assign d_stall   = (d_re | d_we) & ~r_d_ack;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, scoreboard of acks, and
// hand sequences for timing, flush, starvation and reset corners.
module tb_mem_port_arbiter;

  typedef struct {
    int          kind;      // 0 fetch, 1 load, 2 store, 3 load+store (acts as store)
    logic [15:0] addr;
    logic [15:0] wdata;
    int          lat;
    logic [15:0] exp_rdata;
  } vec_t;

  typedef struct {
    bit          is_data;
    logic [15:0] rdata;
  } sb_t;

  logic        clk;
  logic        rst_n;
  logic        if_req, if_flush, if_ack, if_stall;
  logic [15:0] if_addr, if_rdata;
  logic        d_re, d_we, d_ack, d_stall;
  logic [15:0] d_addr, d_wdata, d_rdata;
  logic        mem_req, mem_we, mem_ack;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  int          checks;
  int          failures;
  bit          sb_en;
  sb_t         sb_q[$];
  logic [15:0] grant_q[$];
  logic [15:0] mem_model [logic [15:0]];
  int          mem_lat;
  int          mem_count;
  logic [15:0] log_addr, log_wdata;
  logic        log_we;
  logic [15:0] exp_if, exp_d;
  vec_t        tbl[11];

  mem_port_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_ack(if_ack), .if_rdata(if_rdata), .if_stall(if_stall),
    .d_re(d_re), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_stall(d_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory model: acks after mem_lat wait cycles, logs each completed access.
  initial begin
    int cnt;
    cnt = 0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    mem_count = 0;
    forever begin
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      if (mem_req === 1'b1) begin
        if (cnt >= mem_lat) begin
          cnt = 0;
          mem_ack = 1'b1;
          log_addr = mem_addr;
          log_we = mem_we;
          log_wdata = mem_wdata;
          mem_count++;
          if (mem_we) begin
            mem_model[mem_addr] = mem_wdata;
            mem_rdata = '0;
          end else begin
            mem_rdata = mem_model.exists(mem_addr) ? mem_model[mem_addr] : 16'hDEAD;
          end
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // Ack monitor: pops the scoreboard and records every new memory grant.
  initial begin
    logic prev_req;
    sb_t  e;
    prev_req = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_req === 1'b1 && prev_req !== 1'b1) grant_q.push_back(mem_addr);
      prev_req = mem_req;
      if (sb_en && (if_ack === 1'b1 || d_ack === 1'b1)) begin
        if (if_ack === 1'b1 && d_ack === 1'b1) begin
          checks++; failures++;
          $display("FAIL dual_ack: if_ack and d_ack both high at %0t", $time);
        end else if (sb_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL stray_ack: if_ack=%b d_ack=%b with nothing expected at %0t",
                   if_ack, d_ack, $time);
        end else begin
          e = sb_q.pop_front();
          chk("ack_owner", 16'(d_ack), 16'(e.is_data));
          chk(d_ack ? "d_rdata" : "if_rdata", d_ack ? d_rdata : if_rdata, e.rdata);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic wait_ack(input bit is_data, input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if ((is_data ? d_ack : if_ack) === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++; failures++;
      $display("FAIL ack_timeout: %s ack not seen within %0d cycles", is_data ? "data" : "fetch", budget);
    end
  endtask

  task automatic do_txn(input vec_t v);
    sb_t e;
    mem_lat = v.lat;
    @(posedge clk); #1;
    if (v.kind == 0) begin
      if_req = 1'b1; if_addr = v.addr;
      exp_if = v.exp_rdata;
    end else begin
      d_addr = v.addr; d_wdata = v.wdata;
      d_re = (v.kind == 1 || v.kind == 3);
      d_we = (v.kind >= 2);
      exp_d = v.exp_rdata;
    end
    e.is_data = (v.kind != 0);
    e.rdata = v.exp_rdata;
    sb_q.push_back(e);
    wait_ack(v.kind != 0, v.lat + 10);
    @(posedge clk); #1;
    if_req = 1'b0; d_re = 1'b0; d_we = 1'b0;
  endtask

  initial begin
    sb_t e;
    int  c0;
    bit  seen;
    logic [15:0] exp_g;

    rst_n = 1'b0;
    if_req = 0; if_addr = '0; if_flush = 0;
    d_re = 0; d_we = 0; d_addr = '0; d_wdata = '0;
    mem_lat = 0; sb_en = 1'b1;
    checks = 0; failures = 0;
    exp_if = '0; exp_d = '0;
    mem_model[16'h0010] = 16'h0123;
    mem_model[16'h0200] = 16'h4567;
    mem_model[16'h0020] = 16'h1111;
    mem_model[16'h0202] = 16'h2222;
    mem_model[16'h0400] = 16'h0A0A;

    tbl[0]  = '{0, 16'h0020, 16'h0000, 2, 16'h1111};
    tbl[1]  = '{1, 16'h0202, 16'h0000, 0, 16'h2222};
    tbl[2]  = '{2, 16'h0300, 16'hBEEF, 2, 16'h2222};
    tbl[3]  = '{1, 16'h0300, 16'h0000, 0, 16'hBEEF};
    tbl[4]  = '{0, 16'h0010, 16'h0000, 3, 16'h0123};
    tbl[5]  = '{1, 16'h0400, 16'h0000, 1, 16'h0A0A};
    tbl[6]  = '{2, 16'h0400, 16'hCAFE, 0, 16'h0A0A};
    tbl[7]  = '{1, 16'h0400, 16'h0000, 1, 16'hCAFE};
    tbl[8]  = '{0, 16'h0400, 16'h0000, 0, 16'hCAFE};
    tbl[9]  = '{3, 16'h0500, 16'h1234, 1, 16'hCAFE};
    tbl[10] = '{1, 16'h0500, 16'h0000, 0, 16'h1234};

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_req", 16'(mem_req), 16'h0);
    chk("rst_mem_addr", mem_addr, 16'h0);
    chk("rst_if_ack", 16'(if_ack), 16'h0);
    chk("rst_d_ack", 16'(d_ack), 16'h0);
    chk("rst_if_rdata", if_rdata, 16'h0);
    chk("rst_d_rdata", d_rdata, 16'h0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Single fetch, one memory wait cycle: exact cycle timing
    mem_lat = 1;
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 16'h0010;
    e.is_data = 1'b0; e.rdata = 16'h0123; sb_q.push_back(e); exp_if = 16'h0123;
    @(negedge clk);
    chk("grant_lat_idle_req", 16'(mem_req), 16'h0);
    chk("fetch_stall", 16'(if_stall), 16'h1);
    @(negedge clk);
    chk("grant_lat_req", 16'(mem_req), 16'h1);
    chk("fetch_mem_addr", mem_addr, 16'h0010);
    chk("fetch_mem_we", 16'(mem_we), 16'h0);
    @(negedge clk);
    chk("wait_mem_ack", 16'(mem_ack), 16'h1);
    chk("wait_if_ack", 16'(if_ack), 16'h0);
    chk("busy_hold_req", 16'(mem_req), 16'h1);
    @(negedge clk);
    chk("resp_if_ack", 16'(if_ack), 16'h1);
    chk("resp_mem_req", 16'(mem_req), 16'h0);
    chk("resp_if_stall", 16'(if_stall), 16'h0);
    @(posedge clk); #1 if_req = 1'b0;

    // Vector table
    foreach (tbl[i]) begin
      do_txn(tbl[i]);
      chk("tbl_mem_addr", log_addr, tbl[i].addr);
      chk("tbl_mem_we", 16'(log_we), 16'(tbl[i].kind >= 2));
      if (tbl[i].kind >= 2) chk("tbl_mem_wdata", log_wdata, tbl[i].wdata);
    end

    // Simultaneous fetch and load: data first, then fetch
    mem_lat = 0;
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 16'h0010;
    d_re = 1'b1; d_addr = 16'h0200;
    e.is_data = 1'b1; e.rdata = 16'h4567; sb_q.push_back(e);
    e.is_data = 1'b0; e.rdata = 16'h0123; sb_q.push_back(e);
    exp_d = 16'h4567; exp_if = 16'h0123;
    @(negedge clk);
    @(negedge clk);
    chk("prio_first_addr", mem_addr, 16'h0200);
    wait_ack(1'b1, 10);
    @(posedge clk); #1 d_re = 1'b0;
    wait_ack(1'b0, 10);
    @(posedge clk); #1 if_req = 1'b0;

    // Flush while fetch owns BUSY: memory completes, no ack, rdata kept
    mem_lat = 3;
    c0 = mem_count;
    @(posedge clk); #1;
    if_req = 1'b1; if_addr = 16'h0020;
    @(negedge clk);
    @(negedge clk);
    chk("flush_busy_req", 16'(mem_req), 16'h1);
    @(posedge clk); #1 if_flush = 1'b1; if_req = 1'b0;
    @(posedge clk); #1 if_flush = 1'b0;
    seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (if_ack === 1'b1) seen = 1'b1;
    end
    chk("flush_no_ack", 16'(seen), 16'h0);
    chk("flush_mem_done", 16'(mem_count - c0), 16'h1);
    chk("flush_rdata_kept", if_rdata, exp_if);
    do_txn('{0, 16'h0020, 16'h0000, 1, 16'h1111});

    // Flush during the response cycle cancels the ack
    mem_lat = 0;
    @(posedge clk); #1 if_req = 1'b1; if_addr = 16'h0010;
    @(posedge clk);
    @(posedge clk); #1 if_flush = 1'b1; if_req = 1'b0;
    @(negedge clk);
    chk("flush_resp_ack", 16'(if_ack), 16'h0);
    @(posedge clk); #1 if_flush = 1'b0;
    repeat (3) @(posedge clk);

    // Continuous data plus waiting fetch: grant order
    sb_en = 1'b0;
    grant_q.delete();
    mem_lat = 0;
    @(posedge clk); #1;
    d_re = 1'b1; d_addr = 16'h0200;
    if_req = 1'b1; if_addr = 16'h0010;
    for (int i = 0; i < 100 && grant_q.size() < 6; i++) @(negedge clk);
    @(posedge clk); #1 d_re = 1'b0; if_req = 1'b0;
    repeat (8) @(posedge clk);
    sb_en = 1'b1;
    chk("starve_grants", 16'(grant_q.size() >= 6), 16'h1);
    for (int i = 0; i < 6 && i < grant_q.size(); i++) begin
`ifdef MEM_ARB_FAIRNESS_EN
      exp_g = (i == 4) ? 16'h0010 : 16'h0200;
`else
      exp_g = 16'h0200;
`endif
      chk("starve_grant_addr", grant_q[i], exp_g);
    end

    // Reset during BUSY: outputs clear at once, no ack afterwards
    mem_lat = 5;
    @(posedge clk); #1 if_req = 1'b1; if_addr = 16'h0010;
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy_req", 16'(mem_req), 16'h1);
    @(posedge clk); #1 if_req = 1'b0; rst_n = 1'b0;
    #1;
    chk("arst_mem_req", 16'(mem_req), 16'h0);
    chk("arst_mem_addr", mem_addr, 16'h0);
    chk("arst_mem_we", 16'(mem_we), 16'h0);
    chk("arst_mem_wdata", mem_wdata, 16'h0);
    chk("arst_if_ack", 16'(if_ack), 16'h0);
    chk("arst_d_ack", 16'(d_ack), 16'h0);
    chk("arst_if_rdata", if_rdata, 16'h0);
    chk("arst_d_rdata", d_rdata, 16'h0);
    chk("arst_stalls", 16'({if_stall, d_stall}), 16'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (if_ack === 1'b1 || d_ack === 1'b1 || mem_req === 1'b1) seen = 1'b1;
    end
    chk("post_rst_quiet", 16'(seen), 16'h0);
    chk("sb_drained", 16'(sb_q.size()), 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares the single-ported unified memory between the instruction-fetch stage and the data-memory stage. The data-memory stage drives the load/store requests produced by the decoder's Mem_re/Mem_we. The block sequences each access as a request/acknowledge transaction on the memory side. It returns a registered acknowledge and read data to the winning requester and gives the pipeline per-requester stall signals. It sits between the fetch/MEM stages and the memory wrapper.

Parameters:
ADDR_W, 16, address width (matches the 16-bit PC/i_addr)
DATA_W, 16, data width (matches the instruction and register width)
STARVE_MAX, 4, consecutive data grants allowed while fetch waits (fairness build only); legal range 1..15

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
if_req  in  1  fetch request; held until if_ack or if_flush
if_addr  in  ADDR_W  fetch address (PC)
if_flush  in  1  abandon the pending or in-flight fetch (redirect on jump/taken branch)
if_ack  out  1  one-cycle pulse; if_rdata valid
if_rdata  out  DATA_W  fetched instruction, registered
if_stall  out  1  if_req & ~if_ack
d_re  in  1  load request (Mem_re)
d_we  in  1  store request (Mem_we)
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_ack  out  1  one-cycle pulse completing a load or store
d_rdata  out  DATA_W  load data, registered; unchanged on a store
d_stall  out  1  (d_re|d_we) & ~d_ack
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  1 = write
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_ack  in  1  memory completion (same cycle or any later cycle after mem_req)
mem_rdata  in  DATA_W  valid when mem_ack=1 and mem_we=0

Behaviour:
- Clock and reset: one clock (clk); asynchronous active-low reset (rst_n).
- Reset values: all outputs 0, state IDLE, owner=FETCH, starve count 0. Reset mid-transaction abandons the access; no ack is issued.
- FSM states IDLE, BUSY, RESP; owner register in {FETCH, DATA}.
- IDLE:
  - If any request is present, pick the winner, register mem_addr/mem_we/mem_wdata from it and set mem_req=1. Go to BUSY.
  - Grant latency from request to mem_req is 1 cycle.
- Arbitration: data beats fetch (fixed priority); the fairness build is described under Optional Feature.
- BUSY:
  - mem_* held stable.
  - On mem_ack: drop mem_req next cycle; capture mem_rdata into the owner's rdata register if it is a read. Go to RESP.
- RESP:
  - Pulse the owner's ack for exactly one cycle. Go to IDLE.
  - Minimum 3 cycles per access; there is no back-to-back grant from RESP.
- d_re & d_we both set: illegal; treated as a store.
- if_flush:
  - In IDLE with fetch pending: no grant to fetch that cycle.
  - Fetch owns BUSY: the transaction completes on the memory side (mem_req is never withdrawn early), but if_ack and if_rdata update are suppressed in RESP.
  - Flush during RESP for fetch: the ack is suppressed.
- Requesters must hold req/addr/wdata stable until ack; the arbiter samples them only in IDLE.
- if_rdata/d_rdata hold their last value between acks.

Optional Feature:
MEM_ARB_FAIRNESS_EN
- Defined:
  - A 4-bit starve counter increments on each data grant made while if_req is pending, and clears on any fetch grant.
  - When the counter reaches STARVE_MAX with both requests present, fetch wins.
- Undefined: strict data priority; the counter logic is absent.

Decomposition:
- Package mem_arb_pkg: state enum {IDLE, BUSY, RESP}; owner enum {FETCH, DATA}; default width constants.
- No sub-module required. A small mem_arb_starve_ctr is natural only when MEM_ARB_FAIRNESS_EN is defined.

Test Plan:
- Single fetch: if_addr=0x0010, memory returns 0x0123 with one wait cycle -> mem_req the cycle after if_req; if_ack pulses one cycle after mem_ack; if_rdata=0x0123.
- Simultaneous requests: if_req and a d_re load of 0x0200 -> data granted first with d_rdata=mem value; fetch granted in the next IDLE.
- Store: d_we, d_addr=0x0300, d_wdata=0xBEEF -> mem_we=1, mem_wdata=0xBEEF; d_ack pulses; d_rdata unchanged.
- Flush: if_flush asserted while a fetch is BUSY -> the memory access completes, no if_ack, if_rdata unchanged; the next fetch proceeds normally.
- Fairness build (STARVE_MAX=4): continuous data requests plus if_req -> the 5th grant goes to fetch. Non-fairness build -> fetch is never granted while d_re stays high.
- Reset asserted during BUSY -> all outputs 0 immediately; after release, no stray ack.
